// File: rtl/flag_cond_unit.sv
// flag_cond_unit: architectural status register {N,V,C,Z}, branch condition
// evaluation with a registered taken/not-taken result, and a small LIFO flag
// stack used to save/restore the status register around calls and interrupts.
module flag_cond_unit #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       N_in,
    input  logic       V_in,
    input  logic       C_in,
    input  logic       Z_in,
    input  logic       FLAG_WE,
    input  logic [3:0] COND,
    input  logic       COND_VALID,
    input  logic       PUSH,
    input  logic       POP,
    output logic [3:0] FLAGS,
    output logic       TAKEN,
    output logic       TAKEN_VALID,
    output logic       STK_FULL,
    output logic       STK_EMPTY,
    output logic       STK_ERR
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);

    // Condition code decode; f is {N,V,C,Z}.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic n, v, c, z;
        logic r;
        n = f[3];
        v = f[2];
        c = f[1];
        z = f[0];
        r = 1'b0;
        case (cc)
            4'h0: r = z;
            4'h1: r = ~z;
            4'h2: r = c;
            4'h3: r = ~c;
            4'h4: r = n;
            4'h5: r = ~n;
            4'h6: r = v;
            4'h7: r = ~v;
            4'h8: r = c & ~z;
            4'h9: r = ~c | z;
            4'hA: r = (n == v);
            4'hB: r = (n != v);
            4'hC: r = ~z & (n == v);
            4'hD: r = z | (n != v);
            4'hE: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [3:0]       flags_q, flags_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             taken_q, taken_d;
    logic             tvalid_q, tvalid_d;
    logic             err_q, err_d;
    logic [3:0]       stk_q [DEPTH];

    logic             full, empty;
    logic             push_req, pop_req;
    logic             push_ok, pop_ok;
    logic             err_set;
    logic [PTR_W-1:0] wr_idx, top_idx;
    logic [3:0]       stk_top;

    assign full      = (cnt_q == CNT_FULL);
    assign empty     = (cnt_q == '0);

    // Simultaneous PUSH and POP cancel each other and are not an error.
    assign push_req  = PUSH & ~POP;
    assign pop_req   = POP & ~PUSH;
    assign push_ok   = push_req & ~full;
    assign pop_ok    = pop_req & ~empty;
    assign err_set   = (push_req & full) | (pop_req & empty);

    // DEPTH is a power of two, so the low count bits index the next free slot
    // and wrap correctly to DEPTH-1 for the top entry when the stack is full.
    assign wr_idx    = cnt_q[PTR_W-1:0];
    assign top_idx   = cnt_q[PTR_W-1:0] - IDX_ONE;
    assign stk_top   = stk_q[top_idx];

    // Next-state: pop beats flag write; evaluation sees the bypassed flags.
    always_comb begin
        flags_d  = flags_q;
        cnt_d    = cnt_q;
        err_d    = err_q | err_set;
        tvalid_d = COND_VALID;
        taken_d  = taken_q;

        if (pop_ok) begin
            flags_d = stk_top;
        end else if (FLAG_WE) begin
            flags_d = {N_in, V_in, C_in, Z_in};
        end

        if (push_ok) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop_ok) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        if (COND_VALID) begin
            taken_d = cond_eval(COND, flags_d);
        end
    end

    // Status, count, error and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q  <= 4'b0000;
            cnt_q    <= '0;
            taken_q  <= 1'b0;
            tvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
            taken_q  <= taken_d;
            tvalid_q <= tvalid_d;
            err_q    <= err_d;
        end
    end

    // Stack storage; saves the pre-update flags so a push with a flag write
    // keeps the old value and loads the new one.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            stk_q[wr_idx] <= flags_q;
        end
    end

    assign FLAGS       = flags_q;
    assign TAKEN       = taken_q;
    assign TAKEN_VALID = tvalid_q;
    assign STK_FULL    = full;
    assign STK_EMPTY   = empty;
    assign STK_ERR     = err_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Bench for flag_cond_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_flag_cond_unit;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       N_in, V_in, C_in, Z_in;
    logic       FLAG_WE;
    logic [3:0] COND;
    logic       COND_VALID;
    logic       PUSH, POP;
    logic [3:0] FLAGS;
    logic       TAKEN, TAKEN_VALID, STK_FULL, STK_EMPTY, STK_ERR;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // Reference model state
    logic [3:0] m_flags;
    logic [3:0] m_stk[$];
    logic       m_err;
    logic       m_taken;
    logic       m_tvalid;

    flag_cond_unit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .N_in(N_in), .V_in(V_in), .C_in(C_in), .Z_in(Z_in),
        .FLAG_WE(FLAG_WE), .COND(COND), .COND_VALID(COND_VALID),
        .PUSH(PUSH), .POP(POP),
        .FLAGS(FLAGS), .TAKEN(TAKEN), .TAKEN_VALID(TAKEN_VALID),
        .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY), .STK_ERR(STK_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_cond(input logic [3:0] cc, input logic [3:0] f);
        bit n, v, c, z;
        n = f[3]; v = f[2]; c = f[1]; z = f[0];
        case (int'(cc))
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        logic [3:0] nxt;
        bit popped;
        if (!rst_n) begin
            m_flags = 4'b0000; m_stk.delete(); m_err = 0; m_taken = 0; m_tvalid = 0;
            return;
        end
        nxt = m_flags;
        popped = 0;
        if (PUSH && !POP) begin
            if (m_stk.size() == DEPTH) m_err = 1;
            else m_stk.push_back(m_flags);
        end
        if (POP && !PUSH) begin
            if (m_stk.size() == 0) m_err = 1;
            else begin nxt = m_stk.pop_back(); popped = 1; end
        end
        if (!popped && FLAG_WE) nxt = {N_in, V_in, C_in, Z_in};
        if (COND_VALID) m_taken = ref_cond(COND, nxt);
        m_tvalid = COND_VALID;
        m_flags = nxt;
    endtask

    task automatic cyc(input logic r, input logic we, input logic [3:0] fin,
                       input logic cv, input logic [3:0] cc,
                       input logic pu, input logic po);
        rst_n = r; FLAG_WE = we;
        {N_in, V_in, C_in, Z_in} = fin;
        COND_VALID = cv; COND = cc; PUSH = pu; POP = po;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load(input logic [3:0] f);
        cyc(1, 1, f, 0, 4'h0, 0, 0);
    endtask

    // Continuous comparison against the reference model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("flags",  FLAGS, m_flags);
            check("tvalid", {3'b0, TAKEN_VALID}, {3'b0, m_tvalid});
            check("taken",  {3'b0, TAKEN}, {3'b0, m_taken});
            check("full",   {3'b0, STK_FULL}, {3'b0, m_stk.size() == DEPTH});
            check("empty",  {3'b0, STK_EMPTY}, {3'b0, m_stk.size() == 0});
            check("err",    {3'b0, STK_ERR}, {3'b0, m_err});
        end
    end

    initial begin
        rst_n = 0; FLAG_WE = 0; {N_in, V_in, C_in, Z_in} = 4'b0;
        COND = 0; COND_VALID = 0; PUSH = 0; POP = 0;

        // Reset held two edges while a flag write is requested
        cyc(0, 1, 4'b1111, 0, 4'h0, 0, 0);
        cyc(0, 1, 4'b1111, 0, 4'h0, 0, 0);
        check("rst_flags", FLAGS, 4'b0000);
        check("rst_empty", {3'b0, STK_EMPTY}, 4'd1);
        check("rst_err",   {3'b0, STK_ERR}, 4'd0);
        check("rst_tv",    {3'b0, TAKEN_VALID}, 4'd0);
        chk_en = 1;

        // Condition sweep over all flag values and codes
        for (int f = 0; f < 16; f++) begin
            load(4'(f));
            for (int c = 0; c < 16; c++) cyc(1, 0, 4'b0, 1, 4'(c), 0, 0);
        end
        load(4'b1000);
        cyc(1, 0, 4'b0, 1, 4'hA, 0, 0);
        check("ge_1000", {3'b0, TAKEN}, 4'd0);
        cyc(1, 0, 4'b0, 1, 4'hB, 0, 0);
        check("lt_1000", {3'b0, TAKEN}, 4'd1);
        load(4'b0101);
        cyc(1, 0, 4'b0, 1, 4'h8, 0, 0);
        check("hi_0101", {3'b0, TAKEN}, 4'd0);
        cyc(1, 0, 4'b0, 1, 4'h9, 0, 0);
        check("ls_0101", {3'b0, TAKEN}, 4'd1);

        // Bypass: flag write and EQ evaluation in the same cycle
        load(4'b0000);
        cyc(1, 1, 4'b0001, 1, 4'h0, 0, 0);
        check("byp_taken", {3'b0, TAKEN}, 4'd1);
        check("byp_tv",    {3'b0, TAKEN_VALID}, 4'd1);
        check("byp_flags", FLAGS, 4'b0001);
        cyc(1, 0, 4'b0, 0, 4'h0, 0, 0);
        check("tv_pulse",  {3'b0, TAKEN_VALID}, 4'd0);

        // Stack fill, overflow and drain
        load(4'b0001); cyc(1, 0, 4'b0, 0, 4'h0, 1, 0);
        load(4'b0010); cyc(1, 0, 4'b0, 0, 4'h0, 1, 0);
        load(4'b0100); cyc(1, 0, 4'b0, 0, 4'h0, 1, 0);
        load(4'b1000); cyc(1, 0, 4'b0, 0, 4'h0, 1, 0);
        check("fill_full", {3'b0, STK_FULL}, 4'd1);
        check("fill_err0", {3'b0, STK_ERR}, 4'd0);
        cyc(1, 0, 4'b0, 0, 4'h0, 1, 0);
        check("ovf_err", {3'b0, STK_ERR}, 4'd1);
        cyc(1, 0, 4'b0, 0, 4'h0, 0, 1); check("pop1", FLAGS, 4'b1000);
        cyc(1, 0, 4'b0, 0, 4'h0, 0, 1); check("pop2", FLAGS, 4'b0100);
        cyc(1, 0, 4'b0, 0, 4'h0, 0, 1); check("pop3", FLAGS, 4'b0010);
        cyc(1, 0, 4'b0, 0, 4'h0, 0, 1); check("pop4", FLAGS, 4'b0001);
        check("drain_empty", {3'b0, STK_EMPTY}, 4'd1);

        // Collisions
        cyc(0, 0, 4'b0, 0, 4'h0, 0, 0);
        load(4'b0011);
        cyc(1, 1, 4'b1100, 0, 4'h0, 1, 0);
        check("pushwe_flags", FLAGS, 4'b1100);
        cyc(1, 1, 4'b1111, 0, 4'h0, 0, 1);
        check("popwe_flags", FLAGS, 4'b0011);
        cyc(1, 0, 4'b0, 0, 4'h0, 1, 1);
        check("pushpop_flags", FLAGS, 4'b0011);
        check("pushpop_err",   {3'b0, STK_ERR}, 4'd0);
        check("pushpop_empty", {3'b0, STK_EMPTY}, 4'd1);

        // Underflow with flag write, then reset clears the error
        cyc(1, 1, 4'b0110, 0, 4'h0, 0, 1);
        check("unf_err",   {3'b0, STK_ERR}, 4'd1);
        check("unf_flags", FLAGS, 4'b0110);
        cyc(0, 0, 4'b0, 0, 4'h0, 0, 0);
        check("rst_clr_err", {3'b0, STK_ERR}, 4'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 2) == 0),
                4'($urandom),
                ($urandom_range(0, 1) == 1),
                4'($urandom),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0));
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
